// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART top level and its FIFO sub-module:
//   - uart_state_t : state encoding used by both the RX and TX FSMs
//   - DEFAULT_CLKS_PER_BIT / DEFAULT_FIFO_DEPTH : default parameter values
//   - DATA_BITS    : payload width of one 8N1 frame
//   - is_pow2()    : elaboration helper for parameter legality checks
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 10;
  localparam int DEFAULT_FIFO_DEPTH   = 16;
  localparam int DATA_BITS            = 8;

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO with count-based full/empty.
//   clk, rst : clock and synchronous active-high reset
//   push     : write wdata (ignored while full)
//   wdata    : data to write
//   pop      : remove the head entry (ignored while empty)
//   rdata    : head entry; holds the last head while empty, 0 after reset
//   empty    : no entries stored
//   full     : DEPTH entries stored
// -----------------------------------------------------------------------------
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = DATA_BITS,
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_ZERO = '0;
  localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nxt;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is dropped even if a pop happens in the same
  // cycle; this keeps the full case trivially "unchanged".
  assign do_push    = push && (count != CNT_FULL);
  assign do_pop     = pop && (count != CNT_ZERO);
  assign rd_ptr_nxt = rd_ptr + AW'(1);
  assign empty      = (count == CNT_ZERO);
  assign full       = (count == CNT_FULL);

  // NOTE: the storage array has no reset; only pointers, count and the head
  // register are reset, so the array maps onto plain RAM/register cells.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: every sequential assignment uses <= so all registers update from
  // the values present before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdata  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr_nxt;

      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase

      // Registered head: the next head comes either from the array (pop with
      // more entries behind) or straight from wdata (push into an empty FIFO,
      // or push while the only entry is being popped). Otherwise it holds.
      if (do_pop && (count > CNT_ONE)) begin
        rdata <= mem[rd_ptr_nxt];
      end else if (do_push && ((count == CNT_ZERO) ||
                               (do_pop && (count == CNT_ONE)))) begin
        rdata <= wdata;
      end
    end
  end

endmodule

// File: rtl/uart.sv
// -----------------------------------------------------------------------------
// uart
// Full-duplex 8N1 UART with an RX FIFO and a TX FIFO.
//   clk        : single clock, rising edge
//   rst        : synchronous active-high reset
//   rxd        : asynchronous serial input, idle high
//   txd        : registered serial output, idle high
//   wrreq      : push write_data into the TX FIFO (dropped when full)
//   write_data : byte to transmit
//   rdreq      : pop the RX FIFO head (ignored when empty)
//   read_data  : RX FIFO head, show-ahead
//   empty      : RX FIFO holds no bytes
// -----------------------------------------------------------------------------
module uart
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       txd,
  input  logic       wrreq,
  input  logic [7:0] write_data,
  input  logic       rdreq,
  output logic [7:0] read_data,
  output logic       empty
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_cpb
    $error("uart: CLKS_PER_BIT must be at least 4");
  end

  // ---------------------------------------------------------------------------
  // Receive path
  // ---------------------------------------------------------------------------
  logic          rx_meta;
  logic          rx_sync;
  uart_state_t   rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_shift;
  logic          rx_push;
  logic          rx_armed;
  logic          rx_full;

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_sync <= rx_meta;
    end
  end

  // rx_armed is cleared at the end of every frame and set again once the
  // line is seen high, so a stuck-low line cannot retrigger start detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
      rx_push  <= 1'b0;
      rx_armed <= 1'b0;
    end else begin
      rx_push <= 1'b0;
      unique case (rx_state)
        IDLE: begin
          rx_cnt <= '0;
          rx_idx <= '0;
          if (!rx_armed) begin
            if (rx_sync) rx_armed <= 1'b1;
          end else if (!rx_sync) begin
            rx_state <= START;
          end
        end
        START: begin
          // Half a bit in: confirm the start bit, or treat it as a glitch.
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_state <= rx_sync ? IDLE : DATA;
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            if (rx_idx == LAST_BIT) rx_state <= STOP;
            else                    rx_idx   <= rx_idx + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_push  <= rx_sync;  // stop bit 0: framing error, byte discarded
            rx_armed <= 1'b0;
            rx_state <= IDLE;
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push && !rx_full),
    .wdata (rx_shift),
    .pop   (rdreq),
    .rdata (read_data),
    .empty (empty),
    .full  (rx_full)
  );

  // ---------------------------------------------------------------------------
  // Transmit path
  // ---------------------------------------------------------------------------
  uart_state_t   tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_idx;
  logic [7:0]    tx_shift;
  logic [7:0]    tx_head;
  logic          tx_empty;
  logic          tx_full;
  logic          tx_pop;

  // The head is consumed in the same cycle the FSM leaves IDLE.
  assign tx_pop = (tx_state == IDLE) && !tx_empty;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wrreq && !tx_full),
    .wdata (write_data),
    .pop   (tx_pop),
    .rdata (tx_head),
    .empty (tx_empty),
    .full  (tx_full)
  );

  // txd is assigned alongside each state change so the line level is always
  // a flop output and each bit lasts exactly CLKS_PER_BIT cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      txd      <= 1'b1;
    end else begin
      unique case (tx_state)
        IDLE: begin
          tx_cnt <= '0;
          tx_idx <= '0;
          txd    <= 1'b1;
          if (!tx_empty) begin
            tx_shift <= tx_head;
            txd      <= 1'b0;
            tx_state <= START;
          end
        end
        START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            txd      <= tx_shift[0];
            tx_state <= DATA;
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
        DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_idx == LAST_BIT) begin
              txd      <= 1'b1;
              tx_state <= STOP;
            end else begin
              tx_idx   <= tx_idx + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              txd      <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
        STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_state <= IDLE;
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart.sv
// -----------------------------------------------------------------------------
// tb_uart
// Directed bench for uart at CLKS_PER_BIT=10, FIFO_DEPTH=16. Inputs change
// 1 time unit after a rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_uart;

  localparam int CPB   = 10;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       txd;
  logic       wrreq = 1'b0;
  logic [7:0] write_data = 8'h00;
  logic       rdreq = 1'b0;
  logic [7:0] read_data;
  logic       empty;

  int checks   = 0;
  int failures = 0;

  uart #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .txd        (txd),
    .wrreq      (wrreq),
    .write_data (write_data),
    .rdreq      (rdreq),
    .read_data  (read_data),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       expect_push;
  } rx_vec_t;

  typedef struct {
    logic [7:0] data;
  } tx_vec_t;

  rx_vec_t rx_tab[6];
  tx_vec_t tx_tab[4];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      tick(CPB);
    end
    rxd = stop;
    tick(CPB);
    rxd = 1'b1;
  endtask

  task automatic pop_one();
    rdreq = 1'b1;
    tick();
    rdreq = 1'b0;
  endtask

  task automatic push_tx(input logic [7:0] d);
    write_data = d;
    wrreq      = 1'b1;
    tick();
    wrreq      = 1'b0;
  endtask

  // Decode one frame from txd, sampling each bit at its middle.
  task automatic decode_tx(output logic [7:0] d, output logic ok);
    int wait_cnt = 0;
    d  = 8'h00;
    ok = 1'b0;
    while (txd !== 1'b0 && wait_cnt < 400) begin
      tick();
      wait_cnt++;
    end
    if (wait_cnt >= 400) return;
    tick(CPB / 2 - 1);
    if (txd !== 1'b0) return;
    for (int j = 0; j < 8; j++) begin
      tick(CPB);
      d[j] = txd;
    end
    tick(CPB);
    ok = (txd === 1'b1);
  endtask

  initial begin
    logic [9:0] aa_bits;
    logic [7:0] got;
    logic       ok;
    int         lat;
    int         bad;

    rx_tab[0] = '{data: 8'h2D, stop: 1'b1, expect_push: 1'b1};
    rx_tab[1] = '{data: 8'hA5, stop: 1'b0, expect_push: 1'b0};
    rx_tab[2] = '{data: 8'h0F, stop: 1'b1, expect_push: 1'b1};
    rx_tab[3] = '{data: 8'h00, stop: 1'b1, expect_push: 1'b1};
    rx_tab[4] = '{data: 8'hFF, stop: 1'b1, expect_push: 1'b1};
    rx_tab[5] = '{data: 8'h80, stop: 1'b1, expect_push: 1'b1};

    tx_tab[0] = '{data: 8'h00};
    tx_tab[1] = '{data: 8'hFF};
    tx_tab[2] = '{data: 8'h5A};
    tx_tab[3] = '{data: 8'h81};

    // start bit, bits 0..7 of 0xAA LSB first, stop bit (index 0 first)
    aa_bits = 10'b11_0101_0100;

    // Reset state
    tick(3);
    check("reset_txd", txd, 1);
    check("reset_empty", empty, 1);
    check("reset_read_data", read_data, 8'h00);
    rst = 1'b0;
    tick(2);

    // RX single byte
    send_frame(8'h2D, 1'b1);
    check("rx1_empty", empty, 0);
    check("rx1_data", read_data, 8'h2D);
    pop_one();
    check("rx1_empty_after_pop", empty, 1);

    // RX back-to-back, third read ignored
    send_frame(8'h2D, 1'b1);
    send_frame(8'h0F, 1'b1);
    tick(5);
    check("b2b_head0", read_data, 8'h2D);
    rdreq = 1'b1;
    tick();
    check("b2b_head1", read_data, 8'h0F);
    check("b2b_not_empty", empty, 0);
    tick();
    check("b2b_empty", empty, 1);
    tick();
    rdreq = 1'b0;
    check("b2b_empty_after_extra_read", empty, 1);
    check("b2b_stable_head", read_data, 8'h0F);

    // RX vector table (includes a framing error followed by valid frames)
    foreach (rx_tab[k]) begin
      send_frame(rx_tab[k].data, rx_tab[k].stop);
      tick(2 * CPB);
      check($sformatf("rxtab%0d_empty", k), empty, !rx_tab[k].expect_push);
      if (rx_tab[k].expect_push) begin
        check($sformatf("rxtab%0d_data", k), read_data, rx_tab[k].data);
        pop_one();
        check($sformatf("rxtab%0d_popped", k), empty, 1);
      end
    end

    // Start glitch of 3 cycles, then a valid frame
    rxd = 1'b0;
    tick(3);
    rxd = 1'b1;
    tick(12 * CPB);
    check("glitch_no_push", empty, 1);
    send_frame(8'h55, 1'b1);
    tick(2);
    check("glitch_recover_empty", empty, 0);
    check("glitch_recover_data", read_data, 8'h55);
    pop_one();

    // TX single byte 0xAA: latency and exact waveform
    push_tx(8'hAA);
    lat = 0;
    while (txd !== 1'b0 && lat < 6) begin
      tick();
      lat++;
    end
    check("tx_latency_le3", (lat >= 1 && lat <= 3), 1);
    bad = 0;
    for (int i = 0; i < 10 * CPB; i++) begin
      if (txd !== aa_bits[i / CPB]) bad++;
      tick();
    end
    check("tx_aa_waveform_errors", bad, 0);
    bad = 0;
    for (int i = 0; i < 3 * CPB; i++) begin
      if (txd !== 1'b1) bad++;
      tick();
    end
    check("tx_aa_idle_after", bad, 0);

    // TX vector table
    foreach (tx_tab[k]) begin
      push_tx(tx_tab[k].data);
      decode_tx(got, ok);
      check($sformatf("txtab%0d_frame_ok", k), ok, 1);
      check($sformatf("txtab%0d_data", k), got, tx_tab[k].data);
    end
    tick(2 * CPB);

    // RX overflow: DEPTH+1 frames back to back, the last one is dropped
    for (int i = 0; i <= DEPTH; i++) send_frame(8'h40 + 8'(i), 1'b1);
    tick(5);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (empty !== 1'b0 || read_data !== 8'h40 + 8'(i)) bad++;
      pop_one();
    end
    check("rx_ovf_order_errors", bad, 0);
    check("rx_ovf_extra_dropped", empty, 1);

    // TX overflow: 18 consecutive writes; the transmitter takes the first
    // byte out during the burst, so 17 bytes fit and the 18th is dropped.
    bad = 0;
    fork
      begin
        for (int i = 0; i < DEPTH + 2; i++) push_tx(8'h60 + 8'(i));
      end
      begin
        logic [7:0] d;
        logic       fok;
        for (int i = 0; i < DEPTH + 1; i++) begin
          decode_tx(d, fok);
          if (!fok || d !== 8'h60 + 8'(i)) bad++;
        end
      end
    join
    check("tx_ovf_frame_errors", bad, 0);
    bad = 0;
    for (int i = 0; i < 30 * CPB; i++) begin
      if (txd !== 1'b1) bad++;
      tick();
    end
    check("tx_ovf_extra_dropped", bad, 0);

    // Reset mid-frame on both paths
    send_frame(8'h3C, 1'b1);
    tick(2);
    check("pre_rst_rx_not_empty", empty, 0);
    push_tx(8'h00);
    rxd = 1'b0;
    tick(3 * CPB);
    check("pre_rst_txd_low", txd, 0);
    rst = 1'b1;
    tick();
    check("rst_txd_high", txd, 1);
    check("rst_empty", empty, 1);
    check("rst_read_data", read_data, 8'h00);
    rst = 1'b0;
    rxd = 1'b1;
    bad = 0;
    for (int i = 0; i < 15 * CPB; i++) begin
      if (txd !== 1'b1) bad++;
      tick();
    end
    check("post_rst_tx_aborted", bad, 0);
    check("post_rst_rx_discarded", empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart.md
UART -- requirements
Module: uart

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10, meaning clk cycles per serial bit; the minimum legal value is 4.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning entries per FIFO; it SHALL be a power of two.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port rxd, input, 1 bit: serial receive line, asynchronous, idle high.
REQ-006 SHALL have port txd, output, 1 bit: serial transmit line, idle high.
REQ-007 SHALL have port wrreq, input, 1 bit: push write_data into the TX FIFO.
REQ-008 SHALL have port write_data, input, 8 bits: byte to transmit.
REQ-009 SHALL have port rdreq, input, 1 bit: pop the RX FIFO head.
REQ-010 SHALL have port read_data, output, 8 bits: RX FIFO head (show-ahead).
REQ-011 SHALL have port empty, output, 1 bit: high when the RX FIFO holds no bytes.

Function
REQ-012 SHALL use frame format 8N1: start bit 0, 8 data bits LSB first, stop bit 1, each bit lasting CLKS_PER_BIT clk cycles.
REQ-013 SHALL pass rxd through a 2-flop synchronizer, reset value 1, before any use.
REQ-014 RX FSM SHALL have states IDLE, START, DATA, STOP.
  - IDLE -> START on synchronized rxd==0.
  - In START, at CLKS_PER_BIT/2 cycles it re-samples: 0 -> DATA; 1 -> IDLE (glitch, nothing pushed).
  - In DATA, it samples every CLKS_PER_BIT cycles at mid-bit, shifting in LSB first; after 8 bits -> STOP.
  - In STOP, it samples at mid-bit: 1 -> push byte to RX FIFO; 0 -> framing error, byte discarded.
  - It then returns to IDLE and waits for rxd==1 before arming a new start detection.
REQ-015 A received byte SHALL be pushed on exactly one cycle; if the RX FIFO is full, the byte SHALL be dropped and the FIFO left unchanged.
REQ-016 RX FIFO behaviour:
  - read_data = head entry while empty==0; value undefined-but-stable (last head) while empty==1.
  - rdreq pops one entry per cycle.
  - rdreq while empty SHALL be ignored.
REQ-017 empty SHALL deassert the cycle after a push into an empty FIFO; a push and a pop in the same cycle with count>0 leave count unchanged.
REQ-018 TX FIFO behaviour:
  - wrreq pushes write_data in one cycle.
  - wrreq when the TX FIFO is full SHALL be dropped silently.
  - A simultaneous push and pop is legal.
REQ-019 TX FSM SHALL have states IDLE, START, DATA, STOP.
  - In IDLE with the TX FIFO non-empty: pop the head into the shift register and go to START.
  - It drives each bit for CLKS_PER_BIT cycles.
  - After STOP it returns to IDLE, so back-to-back bytes have no extra idle gap beyond one clk cycle.
REQ-020 txd SHALL be registered, with no combinational path from inputs.
REQ-021 Latency: the wrreq cycle to the txd falling edge (start bit) SHALL be at most 3 clk cycles when the TX path is idle.
REQ-022 RX and TX paths SHALL be fully independent and full-duplex.

Reset
REQ-023 While rst is high, the block SHALL be held in its reset state:
  - both FSMs IDLE, both FIFOs emptied;
  - txd=1, empty=1, read_data=0;
  - bit counters and synchronizer at idle values.
REQ-024 rst asserted mid-frame SHALL abort the frame; the TX line returns high on the next cycle and the partial RX byte is discarded.

Structure
REQ-025 A shared package uart_pkg SHALL hold the FSM state enum (IDLE, START, DATA, STOP) and the default CLKS_PER_BIT and FIFO_DEPTH constants.
REQ-026 One sub-module sync_fifo (8-bit, FIFO_DEPTH, show-ahead, count-based full/empty) SHALL be instantiated twice, once for RX and once for TX.

Verification
REQ-027 Scenario RX single byte: drive 8N1 frame 0x2D at 10 clk/bit -> empty falls after the stop mid-sample, read_data=0x2D, then rdreq for 1 cycle -> empty=1.
REQ-028 Scenario RX back-to-back: frames 0x2D then 0x0F with no idle gap -> two entries in order; three rdreq cycles -> reads 0x2D, 0x0F, the third is ignored, empty=1.
REQ-029 Scenario TX single byte: wrreq with 0xAA for 1 cycle -> txd shows 0,0,1,0,1,0,1,0,1,1, each for 10 cycles, then stays 1.
REQ-030 Scenario errors:
  - a start glitch of 3 cycles -> no byte pushed;
  - a frame with stop bit 0 -> no byte pushed, and the receiver recovers for the next valid frame.
REQ-031 Scenario overflow and reset: push FIFO_DEPTH+1 bytes into each FIFO -> the extra byte is dropped; assert rst mid-TX-frame -> txd=1 and empty=1 the next cycle.
